// File: rtl/sram_rect_filler_pkg.sv
// Shared definitions for the SRAM rectangle test-image filler: FSM states,
// default image geometry and the pixel-pair word packing helper.
package sram_rect_filler_pkg;

  typedef enum logic [1:0] {
    S_IDLE             = 2'd0,
    S_FILL             = 2'd1,
    S_FINISH_FILL_SRAM = 2'd2
  } state_t;

  localparam int H_PIXELS    = 320;
  localparam int V_PIXELS    = 240;
  localparam int RECT_WIDTH  = 40;
  localparam int RECT_HEIGHT = 30;
  // Three 16-bit words carry one pixel pair (six 8-bit channels).
  localparam int FRAME_WORDS = H_PIXELS * V_PIXELS * 3 / 2;
  localparam int ADDR_W      = 18;

  // Packs one of the three words of a pixel pair. Rectangle width is even and
  // pairs start on even x, so both pixels of a pair share one colour.
  function automatic logic [15:0] pack_word(input logic [1:0] phase,
                                            input logic [2:0] colour);
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] w;
    r = {8{colour[2]}};
    g = {8{colour[1]}};
    b = {8{colour[0]}};
    case (phase)
      2'd0:    w = {r, g};
      2'd1:    w = {b, r};
      2'd2:    w = {g, b};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sram_rect_filler_rect_colour_gen.sv
// Tracks the position inside the current 8x8 rectangle grid and produces the
// rectangle colour (rc + rr) mod 8 without any divider. colour_nxt is the
// colour that will apply after the advance requested this cycle.
module rect_colour_gen #(
  parameter int RECT_WIDTH  = sram_rect_filler_pkg::RECT_WIDTH,
  parameter int RECT_HEIGHT = sram_rect_filler_pkg::RECT_HEIGHT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       pair_adv,
  input  logic       line_wrap,
  output logic [2:0] colour,
  output logic [2:0] colour_nxt
);

  localparam logic [5:0] IN_X_LAST = 6'(RECT_WIDTH - 2);
  localparam logic [4:0] IN_Y_LAST = 5'(RECT_HEIGHT - 1);

  logic [5:0] in_x_r, in_x_nxt;
  logic [4:0] in_y_r, in_y_nxt;
  logic [2:0] rc_r, rc_nxt;
  logic [2:0] rr_r, rr_nxt;

  // Next in-rectangle position: clear wins, a line wrap restarts the column walk.
  always_comb begin
    in_x_nxt = in_x_r;
    in_y_nxt = in_y_r;
    rc_nxt   = rc_r;
    rr_nxt   = rr_r;
    if (clear) begin
      in_x_nxt = 6'd0;
      in_y_nxt = 5'd0;
      rc_nxt   = 3'd0;
      rr_nxt   = 3'd0;
    end else if (line_wrap) begin
      in_x_nxt = 6'd0;
      rc_nxt   = 3'd0;
      if (in_y_r == IN_Y_LAST) begin
        in_y_nxt = 5'd0;
        rr_nxt   = rr_r + 3'd1;
      end else begin
        in_y_nxt = in_y_r + 5'd1;
      end
    end else if (pair_adv) begin
      if (in_x_r == IN_X_LAST) begin
        in_x_nxt = 6'd0;
        rc_nxt   = rc_r + 3'd1;
      end else begin
        in_x_nxt = in_x_r + 6'd2;
      end
    end else begin
      in_x_nxt = in_x_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x_r <= 6'd0;
      in_y_r <= 5'd0;
      rc_r   <= 3'd0;
      rr_r   <= 3'd0;
    end else begin
      in_x_r <= in_x_nxt;
      in_y_r <= in_y_nxt;
      rc_r   <= rc_nxt;
      rr_r   <= rr_nxt;
    end
  end

  assign colour     = rc_r + rr_r;
  assign colour_nxt = rc_nxt + rr_nxt;

endmodule

// File: rtl/sram_rect_filler.sv
// Writes a rectangle test image into the SRAM, one word per clock, addresses
// from an incrementing counter. All outputs come straight from registers.
module sram_rect_filler
  import sram_rect_filler_pkg::*;
#(
  parameter int H_PIXELS    = sram_rect_filler_pkg::H_PIXELS,
  parameter int V_PIXELS    = sram_rect_filler_pkg::V_PIXELS,
  parameter int RECT_WIDTH  = sram_rect_filler_pkg::RECT_WIDTH,
  parameter int RECT_HEIGHT = sram_rect_filler_pkg::RECT_HEIGHT
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        Start_i,
  output logic [17:0] SRAM_address_o,
  output logic [15:0] SRAM_write_data_o,
  output logic        SRAM_we_n_o,
  output logic        Busy_o,
  output logic        Done_o
);

  localparam logic [17:0] LAST_ADDR = 18'(H_PIXELS * V_PIXELS * 3 / 2 - 1);
  localparam logic [8:0]  X_LAST    = 9'(H_PIXELS - 2);

  state_t      state_r, state_nxt;
  logic [17:0] addr_r, addr_nxt;
  logic [15:0] data_r, data_nxt;
  logic [1:0]  phase_r, phase_nxt;
  logic [8:0]  x_r, x_nxt;
  logic        we_n_r, we_n_nxt;
  logic        busy_r, busy_nxt;
  logic        done_r, done_nxt;
  logic        clear, pair_adv, line_wrap;
  logic [2:0]  colour, colour_nxt;

  // Colour generator control: hold cleared while idle, step after each pair's last word.
  assign clear     = (state_r == S_IDLE);
  assign pair_adv  = (state_r == S_FILL) && (phase_r == 2'd2) && (addr_r != LAST_ADDR);
  assign line_wrap = pair_adv && (x_r == X_LAST);

  rect_colour_gen #(
    .RECT_WIDTH (RECT_WIDTH),
    .RECT_HEIGHT(RECT_HEIGHT)
  ) u_colour (
    .clk       (Clock_50),
    .rst_n     (Resetn),
    .clear     (clear),
    .pair_adv  (pair_adv),
    .line_wrap (line_wrap),
    .colour    (colour),
    .colour_nxt(colour_nxt)
  );

  // Next state and next values of every output register.
  always_comb begin
    state_nxt = state_r;
    addr_nxt  = addr_r;
    data_nxt  = data_r;
    phase_nxt = phase_r;
    x_nxt     = x_r;
    we_n_nxt  = 1'b1;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_r)
      S_IDLE: begin
        phase_nxt = 2'd0;
        x_nxt     = 9'd0;
        if (Start_i) begin
          state_nxt = S_FILL;
          addr_nxt  = 18'd0;
          data_nxt  = pack_word(2'd0, 3'd0);
          we_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (addr_r == LAST_ADDR) begin
          state_nxt = S_FINISH_FILL_SRAM;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt = addr_r + 18'd1;
          we_n_nxt = 1'b0;
          busy_nxt = 1'b1;
          if (phase_r == 2'd2) begin
            phase_nxt = 2'd0;
            x_nxt     = line_wrap ? 9'd0 : x_r + 9'd2;
            data_nxt  = pack_word(2'd0, colour_nxt);
          end else begin
            phase_nxt = phase_r + 2'd1;
            data_nxt  = pack_word(phase_r + 2'd1, colour);
          end
        end
      end
      S_FINISH_FILL_SRAM: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath and output registers; address and data always move together.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      addr_r  <= 18'd0;
      data_r  <= 16'h0000;
      phase_r <= 2'd0;
      x_r     <= 9'd0;
      we_n_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      addr_r  <= addr_nxt;
      data_r  <= data_nxt;
      phase_r <= phase_nxt;
      x_r     <= x_nxt;
      we_n_r  <= we_n_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
    end
  end

  assign SRAM_address_o    = addr_r;
  assign SRAM_write_data_o = data_r;
  assign SRAM_we_n_o       = we_n_r;
  assign Busy_o            = busy_r;
  assign Done_o            = done_r;

endmodule
